score_counter: RTL

SCORE_COUNTER -- requirements
Module: score_counter

---
 rtl/score_pkg.sv | 24 ++
 rtl/score_counter_if.sv | 36 +++
 rtl/bcd_digit_add.sv | 28 ++
 rtl/score_counter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score counter
//
// Contents:
//   state_t   : game state (IDLE, RUN, OVER)
//   bcd_t     : one BCD digit
//   BLANK     : digit code that turns a display digit off
//   clamp_pts : limits a points value to the largest legal value
package score_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OVER = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BLANK = 4'hF;

   function automatic bcd_t clamp_pts(input logic [3:0] pts, input bcd_t max_v);
      return (pts > max_v) ? max_v : pts;
   endfunction

endpackage

// File: rtl/score_counter_if.sv
// rtl/score_counter_if.sv - player/display side signals of the score counter
//
// Signals:
//   start_i, hit_i, pts_i, tick_i : game inputs (driven by master)
//   dat1_o..dat4_o                : display digits, dat1_o = ones
//   time_o                        : remaining seconds, binary
//   busy_o, over_o                : RUN / OVER state flags
// Modports:
//   master : drives game inputs, observes display and status
//   slave  : the score counter itself
interface score_counter_if;
   import score_pkg::*;

   logic       start_i;
   logic       hit_i;
   logic [3:0] pts_i;
   logic       tick_i;
   bcd_t       dat1_o;
   bcd_t       dat2_o;
   bcd_t       dat3_o;
   bcd_t       dat4_o;
   logic [6:0] time_o;
   logic       busy_o;
   logic       over_o;

   modport master (
      output start_i, hit_i, pts_i, tick_i,
      input  dat1_o, dat2_o, dat3_o, dat4_o, time_o, busy_o, over_o
   );

   modport slave (
      input  start_i, hit_i, pts_i, tick_i,
      output dat1_o, dat2_o, dat3_o, dat4_o, time_o, busy_o, over_o
   );

endinterface

// File: rtl/bcd_digit_add.sv
// rtl/bcd_digit_add.sv - single BCD digit adder with carry
//
// Ports:
//   digit  : BCD digit 0..9
//   addend : value to add, 0..9
//   cin    : carry from the next lower digit
//   sum    : resulting BCD digit
//   cout   : carry into the next higher digit
module bcd_digit_add
   import score_pkg::*;
(
   input  bcd_t       digit,
   input  logic [3:0] addend,
   input  logic       cin,
   output bcd_t       sum,
   output logic       cout
);

   logic [4:0] raw;
   logic [4:0] adj;

   // Worst case 9 + 9 + 1 = 19, so one correction by ten is enough.
   assign raw  = {1'b0, digit} + {1'b0, addend} + {4'd0, cin};
   assign adj  = raw - 5'd10;
   assign cout = (raw > 5'd9);
   assign sum  = cout ? adj[3:0] : raw[3:0];

endmodule

// File: rtl/score_counter.sv
// rtl/score_counter.sv - timed BCD score counter with blanked, blinking display
//
// Parameters:
//   GAME_SEC : game length in seconds (1..99)
//   PTS_MAX  : largest legal points value per hit
// Ports:
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : score_counter_if.slave (game inputs, display digits, status)
module score_counter
   import score_pkg::*;
#(
   parameter int GAME_SEC = 60,
   parameter int PTS_MAX  = 9
)(
   input  logic            clk_i,
   input  logic            rst_i,
   score_counter_if.slave  bus
);

   localparam logic [6:0] GAME_T  = 7'(GAME_SEC);
   localparam bcd_t       PTS_LIM = 4'(PTS_MAX);

   state_t          state_q, state_d;
   bcd_t [3:0]      score_q;
   bcd_t [3:0]      sum;
   bcd_t [3:0]      disp;
   bcd_t [3:0]      dat_q;
   logic [4:0]      carry;
   logic [6:0]      timer_q;
   logic            hit_q;
   logic            blink_q;
   logic            hit_edge;
   logic            start_game;
   logic            tick_last;
   bcd_t            pts_eff;

   assign pts_eff    = clamp_pts(bus.pts_i, PTS_LIM);
   assign hit_edge   = bus.hit_i & ~hit_q;
   assign start_game = bus.start_i & (state_q != ST_RUN);
   assign tick_last  = bus.tick_i & (timer_q == 7'd1);

   // Ripple adder: points enter at the ones digit, higher digits only take carries.
   assign carry[0] = 1'b0;
   for (genvar i = 0; i < 4; i++) begin : g_digit
      bcd_digit_add u_add (
         .digit  (score_q[i]),
         .addend ((i == 0) ? pts_eff : 4'd0),
         .cin    (carry[i]),
         .sum    (sum[i]),
         .cout   (carry[i+1])
      );
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (bus.start_i) state_d = ST_RUN;
         ST_RUN:  if (tick_last)   state_d = ST_OVER;
         ST_OVER: if (bus.start_i) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs straight from registers
   always_comb begin
      bus.busy_o = (state_q == ST_RUN);
      bus.over_o = (state_q == ST_OVER);
      bus.time_o = timer_q;
   end

   // Score, timer, hit history and blink flag. Hit history is sampled in
   // every state so a level held across reset or IDLE never counts later.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         score_q <= '0;
         timer_q <= GAME_T;
         hit_q   <= 1'b0;
         blink_q <= 1'b0;
      end else begin
         hit_q <= bus.hit_i;
         if (start_game) begin
            score_q <= '0;
            timer_q <= GAME_T;
            blink_q <= 1'b0;
         end else if (state_q == ST_RUN) begin
            // Carry out of the thousands digit means the sum passed 9999.
            if (hit_edge) score_q <= carry[4] ? {4{4'd9}} : sum;
            if (bus.tick_i && timer_q != 7'd0) timer_q <= timer_q - 7'd1;
         end else if (state_q == ST_OVER && bus.tick_i) begin
            blink_q <= ~blink_q;
         end
      end
   end

   // Leading-zero blanking; the ones digit is always shown unless blinking off.
   always_comb begin
      disp = score_q;
      if (score_q[3] == 4'd0)      disp[3] = BLANK;
      if (score_q[3:2] == 8'd0)    disp[2] = BLANK;
      if (score_q[3:1] == 12'd0)   disp[1] = BLANK;
      if (state_q == ST_OVER && blink_q) disp = {4{BLANK}};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) dat_q <= {BLANK, BLANK, BLANK, 4'd0};
      else       dat_q <= disp;
   end

   assign bus.dat1_o = dat_q[0];
   assign bus.dat2_o = dat_q[1];
   assign bus.dat3_o = dat_q[2];
   assign bus.dat4_o = dat_q[3];

endmodule
